// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO pointer helpers
package fifo_pkg;

  // Pointer width for a FIFO of the given depth: address bits plus a wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Binary to Gray; operands narrower than 32 bits are zero-extended by the caller.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary; leading zeros of a zero-extended operand do not disturb the prefix XOR.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray_to_binary.sv
// rtl/fifo_gray_to_binary.sv - combinational Gray to binary converter
module fifo_gray_to_binary #(
  parameter int PW = 5
) (
  input  logic [PW-1:0] gray,
  output logic [PW-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar i = 0; i < PW; i++) begin : g_bit
    assign bin[i] = ^gray[PW-1:i];
  end

endmodule

// File: rtl/fifo_write_control.sv
// rtl/fifo_write_control.sv - async FIFO write-domain pointer and flag controller
module fifo_write_control
  import fifo_pkg::*;
#(
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = 14,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          write_clock,
  input  logic          write_reset_n,
  input  logic          write_enable,
  input  logic [PW-1:0] sync_read_pointer,
  input  logic          clear_overflow,
  output logic          mem_write_enable,
  output logic [AW-1:0] write_address,
  output logic [PW-1:0] write_pointer,
  output logic          full,
  output logic          almost_full,
  output logic [PW-1:0] write_level,
  output logic          overflow
);

  localparam logic [PW-1:0] AF_THRESHOLD = PW'(ALMOST_FULL_THRESHOLD);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] write_pointer_q, write_pointer_d;
  logic [PW-1:0] write_level_q, write_level_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] rbin;
  logic          accept;
  logic [PW-1:0] full_gray;

  fifo_gray_to_binary #(.PW(PW)) u_rptr_g2b (
    .gray (sync_read_pointer),
    .bin  (rbin)
  );

  // Next pointer, flags and level; the read pointer is stale by the sync delay, so
  // every flag computed here errs toward "less space" and never reports room that is gone.
  always_comb begin
    accept          = write_enable & ~full_q & write_reset_n;
    wbin_d          = wbin_q + PW'(accept);
    write_pointer_d = PW'(bin2gray(32'(wbin_d)));
    full_gray       = {~sync_read_pointer[PW-1:PW-2], sync_read_pointer[PW-3:0]};
    full_d          = (write_pointer_d == full_gray);
    write_level_d   = wbin_d - rbin;
    almost_full_d   = (write_level_d >= AF_THRESHOLD);
    overflow_d      = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (write_enable & full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin_q          <= '0;
      write_pointer_q <= '0;
      write_level_q   <= '0;
      full_q          <= 1'b0;
      almost_full_q   <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      wbin_q          <= wbin_d;
      write_pointer_q <= write_pointer_d;
      write_level_q   <= write_level_d;
      full_q          <= full_d;
      almost_full_q   <= almost_full_d;
      overflow_q      <= overflow_d;
    end
  end

  assign mem_write_enable = accept;
  assign write_address    = wbin_q[AW-1:0];
  assign write_pointer    = write_pointer_q;
  assign full             = full_q;
  assign almost_full      = almost_full_q;
  assign write_level      = write_level_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_fifo_write_control.sv
// tb/tb_fifo_write_control.sv - directed self-checking bench for fifo_write_control
module tb_fifo_write_control;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PW    = 5;

  logic          write_clock;
  logic          write_reset_n;
  logic          write_enable;
  logic [PW-1:0] sync_read_pointer;
  logic          clear_overflow;
  logic          mem_write_enable;
  logic [AW-1:0] write_address;
  logic [PW-1:0] write_pointer;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] write_level;
  logic          overflow;

  int total;
  int passed;

  fifo_write_control #(.DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(14)) dut (
    .write_clock       (write_clock),
    .write_reset_n     (write_reset_n),
    .write_enable      (write_enable),
    .sync_read_pointer (sync_read_pointer),
    .clear_overflow    (clear_overflow),
    .mem_write_enable  (mem_write_enable),
    .write_address     (write_address),
    .write_pointer     (write_pointer),
    .full              (full),
    .almost_full       (almost_full),
    .write_level       (write_level),
    .overflow          (overflow)
  );

  initial write_clock = 1'b0;
  always #5 write_clock = ~write_clock;

  task automatic tick();
    @(posedge write_clock);
    #1;
  endtask

  task automatic test_reset();
    write_reset_n     = 1'b0;
    write_enable      = 1'b1;
    sync_read_pointer = '0;
    clear_overflow    = 1'b0;
    repeat (3) tick();
    total++; if ({write_pointer, write_level} !== 10'd0) $display("FAIL reset_ptr_level got %h/%h want 0/0", write_pointer, write_level); else passed++;
    total++; if ({full, almost_full, overflow} !== 3'b000) $display("FAIL reset_flags got %b want 000", {full, almost_full, overflow}); else passed++;
    total++; if (write_address !== 4'd0) $display("FAIL reset_addr got %0d want 0", write_address); else passed++;
    total++; if (mem_write_enable !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_write_enable); else passed++;
    write_enable  = 1'b0;
    write_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_enable = 1'b1;
      #1;
      total++; if (mem_write_enable !== 1'b1 || write_address !== AW'(i)) $display("FAIL fill_we_addr[%0d] got %b/%0d want 1/%0d", i, mem_write_enable, write_address, i); else passed++;
      tick();
      total++; if (write_level !== PW'(i + 1)) $display("FAIL fill_level[%0d] got %0d want %0d", i, write_level, i + 1); else passed++;
      total++; if (almost_full !== (i + 1 >= 14)) $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, (i + 1 >= 14)); else passed++;
      total++; if (full !== (i + 1 == 16)) $display("FAIL fill_full[%0d] got %b want %b", i, full, (i + 1 == 16)); else passed++;
    end
    write_enable = 1'b0;
    total++; if (write_pointer !== 5'h18) $display("FAIL fill_ptr got %h want 18", write_pointer); else passed++;
  endtask

  task automatic test_overflow();
    write_enable = 1'b1;
    #1;
    total++; if (mem_write_enable !== 1'b0) $display("FAIL ovf_mem_we got %b want 0", mem_write_enable); else passed++;
    tick();
    total++; if (write_pointer !== 5'h18) $display("FAIL ovf_ptr got %h want 18", write_pointer); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else passed++;
    clear_overflow = 1'b1;
    tick();
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", overflow); else passed++;
    write_enable = 1'b0;
    tick();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
    clear_overflow = 1'b0;
  endtask

  task automatic test_read_release();
    sync_read_pointer = 5'h06;
    tick();
    total++; if (full !== 1'b0) $display("FAIL rel_full got %b want 0", full); else passed++;
    total++; if (write_level !== 5'd12) $display("FAIL rel_level got %0d want 12", write_level); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL rel_almost_full got %b want 0", almost_full); else passed++;
  endtask

  task automatic test_wrap();
    logic [PW-1:0] wbin_m, rbin_m, level_m, prev_gray, exp_gray, diff;
    logic          full_m, acc;
    int            flips;
    bit            wrapped;
    wbin_m  = 5'd16;
    rbin_m  = 5'd4;
    full_m  = 1'b0;
    wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      write_enable = 1'b1;
      if ((i % 3) != 0 && rbin_m != wbin_m) begin
        rbin_m = rbin_m + 5'd1;
      end
      sync_read_pointer = rbin_m ^ (rbin_m >> 1);
      acc       = ~full_m;
      prev_gray = write_pointer;
      #1;
      total++; if (mem_write_enable !== acc) $display("FAIL wrap_mem_we[%0d] got %b want %b", i, mem_write_enable, acc); else passed++;
      tick();
      if (acc && wbin_m == 5'd31) wrapped = 1;
      wbin_m   = wbin_m + PW'(acc);
      level_m  = wbin_m - rbin_m;
      full_m   = (level_m == 5'd16);
      exp_gray = wbin_m ^ (wbin_m >> 1);
      diff     = write_pointer ^ prev_gray;
      flips    = $countones(diff);
      total++; if (write_pointer !== exp_gray) $display("FAIL wrap_ptr[%0d] got %h want %h", i, write_pointer, exp_gray); else passed++;
      total++; if (write_level !== level_m || full !== full_m || almost_full !== (level_m >= 5'd14)) $display("FAIL wrap_flags[%0d] got lvl=%0d f=%b af=%b want lvl=%0d f=%b af=%b", i, write_level, full, almost_full, level_m, full_m, (level_m >= 5'd14)); else passed++;
      total++; if (flips != (acc ? 1 : 0)) $display("FAIL wrap_gray_step[%0d] got %0d bit changes want %0d", i, flips, acc ? 1 : 0); else passed++;
    end
    write_enable = 1'b0;
    total++; if (!wrapped) $display("FAIL wrap_crossed got no 31->0 crossing want one"); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    write_enable = 1'b1;
    repeat (3) tick();
    write_reset_n = 1'b0;
    #1;
    total++; if ({write_pointer, write_level, write_address} !== 14'd0) $display("FAIL mid_rst_state got %h/%h/%h want 0/0/0", write_pointer, write_level, write_address); else passed++;
    total++; if ({full, almost_full, overflow, mem_write_enable} !== 4'b0000) $display("FAIL mid_rst_flags got %b want 0000", {full, almost_full, overflow, mem_write_enable}); else passed++;
    sync_read_pointer = '0;
    tick();
    write_reset_n = 1'b1;
    #1;
    total++; if (mem_write_enable !== 1'b1 || write_address !== 4'd0) $display("FAIL resume_addr0 got %b/%0d want 1/0", mem_write_enable, write_address); else passed++;
    tick();
    total++; if (write_address !== 4'd1 || write_level !== 5'd1) $display("FAIL resume_addr1 got %0d/%0d want 1/1", write_address, write_level); else passed++;
    write_enable = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
